clock_hms_bcd: RTL and testbench

//  Time-of-day counter downstream of the 1 Hz divider: consumes its one-cycle OneHertz

---
 rtl/clock_hms_bcd_pkg.sv | 38 +++
 rtl/clock_hms_bcd_bcd2_mod_cnt.sv | 60 ++++++
 rtl/clock_hms_bcd.sv | 116 +++++++++++
 tb/tb_clock_hms_bcd.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_hms_bcd_pkg.sv
// ---------------------------------------------------------------------------
// clock_hms_bcd_pkg
// Shared constants and helpers for the BCD time-of-day counter.
//   BCD_MAX_DIGIT    largest legal BCD digit
//   SEC_MOD/MIN_MOD  exclusive upper bound for seconds/minutes, in BCD
//   hms_t            packed {hh, mm, ss} time value
//   is_bcd2()        both nibbles of a byte are legal BCD digits
//   hour_mod_ok()    hour modulus is one of the supported values (12, 24)
//   to_bcd2()        small decimal integer (0..99) to packed 2-digit BCD
// ---------------------------------------------------------------------------
package clock_hms_bcd_pkg;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [7:0] SEC_MOD       = 8'h60;
  localparam logic [7:0] MIN_MOD       = 8'h60;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
  } hms_t;

  function automatic logic is_bcd2(input logic [7:0] v);
    return (v[7:4] <= BCD_MAX_DIGIT) && (v[3:0] <= BCD_MAX_DIGIT);
  endfunction

  function automatic logic hour_mod_ok(input int m);
    return (m == 12) || (m == 24);
  endfunction

  function automatic logic [7:0] to_bcd2(input int v);
    logic [7:0] r;
    r[7:4] = 4'((v / 10) % 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

endpackage

// File: rtl/clock_hms_bcd_bcd2_mod_cnt.sv
// ---------------------------------------------------------------------------
// bcd2_mod_cnt
// Two-digit packed-BCD counter that counts 0 .. MOD-1 and wraps to 00.
// Parameters:
//   The decimal modulus is given by the MOD parameter (2..100)
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, clears count to 00
//   en         advance by one on this cycle
//   load       load ld_val this cycle (takes priority over en)
//   ld_val     packed BCD value to load, assumed already validated
//   q          current packed BCD count
//   carry_out  combinational: en is high and the count is at MOD-1, so the
//              next edge wraps to 00; used as the enable of the next stage
// ---------------------------------------------------------------------------
module bcd2_mod_cnt
  import clock_hms_bcd_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] ld_val,
  output logic [7:0] q,
  output logic       carry_out
);

  localparam logic [7:0] LAST = to_bcd2(MOD - 1);

  logic [7:0] q_next;

  // Increment in BCD: the terminal value wraps to 00, a units digit of 9
  // rolls into the tens digit, otherwise only the units digit moves.
  always_comb begin
    q_next = q;
    if (q == LAST) begin
      q_next = 8'h00;
    end else if (q[3:0] == BCD_MAX_DIGIT) begin
      q_next = {q[7:4] + 4'd1, 4'd0};
    end else begin
      q_next = {q[7:4], q[3:0] + 4'd1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 8'h00;
    end else if (load) begin
      q <= ld_val;
    end else if (en) begin
      q <= q_next;
    end
  end

  // A load on the same cycle suppresses the carry so loads never ripple.
  assign carry_out = en && !load && (q == LAST);

endmodule

// File: rtl/clock_hms_bcd.sv
// ---------------------------------------------------------------------------
// clock_hms_bcd
// Time-of-day counter driven by a one-cycle 1 Hz tick. Keeps hours, minutes
// and seconds as packed 2-digit BCD, with run/pause and validated loading.
// Parameters:
//   HOUR_MOD   hour modulus, 12 (00..11) or 24 (00..23)
// Ports:
//   sys_clk    rising-edge system clock
//   sys_rst    synchronous active-high reset; wins over load and tick
//   tick       one-cycle 1 Hz strobe; every high cycle counts
//   run        1 = count ticks, 0 = ticks are dropped
//   load       one-cycle strobe to load ld_hh/ld_mm/ld_ss
//   ld_hh/ld_mm/ld_ss  packed BCD time to load
//   hh/mm/ss   packed BCD time
//   min_pulse  one cycle with the new value when seconds wrap 59->00
//   hr_pulse   one cycle with the new value when minutes wrap 59->00
//   day_pulse  one cycle with the new value when hours wrap to 00
//   load_err   one cycle after a load that was rejected as invalid
// ---------------------------------------------------------------------------
module clock_hms_bcd
  import clock_hms_bcd_pkg::*;
#(
  parameter int HOUR_MOD = 24
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       tick,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] ld_hh,
  input  logic [7:0] ld_mm,
  input  logic [7:0] ld_ss,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       min_pulse,
  output logic       hr_pulse,
  output logic       day_pulse,
  output logic       load_err
);

  // Unsupported hour moduli fall back to a 24-hour clock rather than
  // building a counter with an odd wrap point.
  localparam int         HOUR_MOD_EFF = hour_mod_ok(HOUR_MOD) ? HOUR_MOD : 24;
  localparam logic [7:0] HOUR_LIMIT   = to_bcd2(HOUR_MOD_EFF);

  hms_t ld_time;
  logic load_ok;
  logic load_accept;
  logic count_en;
  logic ss_carry;
  logic mm_carry;
  logic hh_carry;

  assign ld_time = '{hh: ld_hh, mm: ld_mm, ss: ld_ss};

  // Once every nibble is a legal digit, a plain binary compare of the
  // packed BCD bytes orders them the same way as their decimal values.
  always_comb begin
    load_ok = is_bcd2(ld_time.hh) && is_bcd2(ld_time.mm) && is_bcd2(ld_time.ss) &&
              (ld_time.ss < SEC_MOD) && (ld_time.mm < MIN_MOD) &&
              (ld_time.hh < HOUR_LIMIT);
  end

  // A load strobe always swallows a coincident tick, even when the load
  // itself is rejected.
  assign load_accept = load && load_ok;
  assign count_en    = tick && run && !load;

  bcd2_mod_cnt #(.MOD(60)) u_ss (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .en        (count_en),
    .load      (load_accept),
    .ld_val    (ld_time.ss),
    .q         (ss),
    .carry_out (ss_carry)
  );

  bcd2_mod_cnt #(.MOD(60)) u_mm (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .en        (ss_carry),
    .load      (load_accept),
    .ld_val    (ld_time.mm),
    .q         (mm),
    .carry_out (mm_carry)
  );

  bcd2_mod_cnt #(.MOD(HOUR_MOD_EFF)) u_hh (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .en        (mm_carry),
    .load      (load_accept),
    .ld_val    (ld_time.hh),
    .q         (hh),
    .carry_out (hh_carry)
  );

  // Carries are registered so each pulse lines up with the wrapped value
  // it announces; the carry chain itself settles within one cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      min_pulse <= 1'b0;
      hr_pulse  <= 1'b0;
      day_pulse <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      min_pulse <= ss_carry;
      hr_pulse  <= mm_carry;
      day_pulse <= hh_carry;
      load_err  <= load && !load_ok;
    end
  end

endmodule

// File: tb/tb_clock_hms_bcd.sv
// ---------------------------------------------------------------------------
// tb_clock_hms_bcd
// Drives a 24-hour and a 12-hour instance of clock_hms_bcd with the same
// stimulus and checks both against a seconds-since-midnight model.
// ---------------------------------------------------------------------------
module tb_clock_hms_bcd;

  logic       sys_clk = 1'b0;
  logic       sys_rst, tick, run, load;
  logic [7:0] ld_hh, ld_mm, ld_ss;

  logic [7:0] hh24, mm24, ss24, hh12, mm12, ss12;
  logic       min24, hr24, day24, err24, min12, hr12, day12, err12;

  logic [27:0] obs [2];

  int total = 0;
  int bad   = 0;

  int   mods [2] = '{24, 12};
  int   t    [2];
  logic mp   [2];
  logic hp   [2];
  logic dp   [2];
  logic le   [2];

  always #5 sys_clk = ~sys_clk;

  clock_hms_bcd #(.HOUR_MOD(24)) dut24 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tick(tick), .run(run), .load(load),
    .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_ss(ld_ss),
    .hh(hh24), .mm(mm24), .ss(ss24),
    .min_pulse(min24), .hr_pulse(hr24), .day_pulse(day24), .load_err(err24)
  );

  clock_hms_bcd #(.HOUR_MOD(12)) dut12 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tick(tick), .run(run), .load(load),
    .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_ss(ld_ss),
    .hh(hh12), .mm(mm12), .ss(ss12),
    .min_pulse(min12), .hr_pulse(hr12), .day_pulse(day12), .load_err(err12)
  );

  assign obs[0] = {hh24, mm24, ss24, min24, hr24, day24, err24};
  assign obs[1] = {hh12, mm12, ss12, min12, hr12, day12, err12};

  function automatic logic [7:0] bcd(input int x);
    return {4'(x / 10), 4'(x % 10)};
  endfunction

  // Decimal value of a BCD byte, or -1 when a nibble is not a digit.
  function automatic int dec(input logic [7:0] v);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return -1;
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [27:0] expect_of(input int i);
    return {bcd(t[i] / 3600), bcd((t[i] / 60) % 60), bcd(t[i] % 60),
            mp[i], hp[i], dp[i], le[i]};
  endfunction

  // Apply one cycle of inputs, advance the reference model over the edge.
  task automatic cycle(input logic r, input logic tk, input logic rn, input logic ld,
                       input logic [7:0] lh, input logic [7:0] lm, input logic [7:0] ls);
    int h, m, s, day;
    sys_rst = r; tick = tk; run = rn; load = ld;
    ld_hh = lh; ld_mm = lm; ld_ss = ls;
    @(posedge sys_clk);
    for (int i = 0; i < 2; i++) begin
      day = mods[i] * 3600;
      mp[i] = 1'b0; hp[i] = 1'b0; dp[i] = 1'b0; le[i] = 1'b0;
      if (r) begin
        t[i] = 0;
      end else if (ld) begin
        h = dec(lh); m = dec(lm); s = dec(ls);
        if (h >= 0 && m >= 0 && s >= 0 && h < mods[i] && m < 60 && s < 60)
          t[i] = h * 3600 + m * 60 + s;
        else
          le[i] = 1'b1;
      end else if (tk && rn) begin
        mp[i] = (t[i] % 60) == 59;
        hp[i] = (t[i] % 3600) == 3599;
        dp[i] = t[i] == day - 1;
        t[i]  = (t[i] + 1) % day;
      end
    end
    #1;
  endtask

  task automatic idle(input logic rn);
    cycle(1'b0, 1'b0, rn, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== 28'h0 || obs[i] !== expect_of(i)) begin
        bad++;
        $display("[TB] FAIL reset mod%0d got=%h want=%h", mods[i], obs[i], expect_of(i));
      end
    end
  endtask

  task automatic test_minute_rollover();
    int ticks = 0;
    int mins  = 0;
    while (ticks < 61) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1'b1);
      end else begin
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        ticks++;
      end
      if (min24) mins++;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== expect_of(i)) begin
          bad++;
          $display("[TB] FAIL count mod%0d tick=%0d got=%h want=%h",
                   mods[i], ticks, obs[i], expect_of(i));
        end
      end
    end
    total++;
    if (ss24 !== 8'h01 || mm24 !== 8'h01 || mins !== 1) begin
      bad++;
      $display("[TB] FAIL minute_end got=%h:%h pulses=%0d want=01:01 pulses=1",
               mm24, ss24, mins);
    end
  endtask

  task automatic test_day_wrap();
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h23, 8'h59, 8'h58);
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== expect_of(i)) begin
          bad++;
          $display("[TB] FAIL day_wrap mod%0d step=%0d got=%h want=%h",
                   mods[i], k, obs[i], expect_of(i));
        end
      end
    end
    total++;
    if ({hh24, mm24, ss24, min24, hr24, day24} !== {24'h000000, 3'b111}) begin
      bad++;
      $display("[TB] FAIL midnight got=%h%h%h %b%b%b want=000000 111",
               hh24, mm24, ss24, min24, hr24, day24);
    end
    idle(1'b1);
    total++;
    if ({min24, hr24, day24} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL pulse_width got=%b%b%b want=000", min24, hr24, day24);
    end
  endtask

  task automatic test_hour12();
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 8'h59, 8'h59);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    total++;
    if (obs[1] !== {24'h000000, 4'b1110}) begin
      bad++;
      $display("[TB] FAIL wrap12 got=%h want=%h", obs[1], {24'h000000, 4'b1110});
    end
    total++;
    if (obs[0] !== expect_of(0)) begin
      bad++;
      $display("[TB] FAIL noon24 got=%h want=%h", obs[0], expect_of(0));
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h12, 8'h00, 8'h00);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== expect_of(i)) begin
        bad++;
        $display("[TB] FAIL load12 mod%0d got=%h want=%h", mods[i], obs[i], expect_of(i));
      end
    end
  endtask

  task automatic test_invalid_load();
    logic [7:0] bad_vals [3][3] = '{'{8'h05, 8'h10, 8'h5A},
                                     '{8'h05, 8'h60, 8'h10},
                                     '{8'h0A, 8'h10, 8'h10}};
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b1, bad_vals[k][0], bad_vals[k][1], bad_vals[k][2]);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== expect_of(i) || !le[i]) begin
          bad++;
          $display("[TB] FAIL bad_load%0d mod%0d got=%h want=%h",
                   k, mods[i], obs[i], expect_of(i));
        end
      end
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h08, 8'h30, 8'h00);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== {24'h083000, 4'b0000}) begin
        bad++;
        $display("[TB] FAIL good_load mod%0d got=%h want=%h",
                 mods[i], obs[i], {24'h083000, 4'b0000});
      end
    end
  endtask

  task automatic test_pause();
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== expect_of(i)) begin
          bad++;
          $display("[TB] FAIL pause mod%0d k=%0d got=%h want=%h",
                   mods[i], k, obs[i], expect_of(i));
        end
      end
    end
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'h10, 8'h20, 8'h59);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== {24'h102059, 4'b0000}) begin
        bad++;
        $display("[TB] FAIL load_tick mod%0d got=%h want=%h",
                 mods[i], obs[i], {24'h102059, 4'b0000});
      end
    end
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'h10, 8'h7F, 8'h59);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== {24'h102059, 4'b0001}) begin
        bad++;
        $display("[TB] FAIL badload_tick mod%0d got=%h want=%h",
                 mods[i], obs[i], {24'h102059, 4'b0001});
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h12, 8'h34, 8'h56);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 8'h34, 8'h56);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== 28'h0 || obs[i] !== expect_of(i)) begin
        bad++;
        $display("[TB] FAIL reset_mid mod%0d got=%h want=%h", mods[i], obs[i], expect_of(i));
      end
    end
  endtask

  task automatic test_random();
    logic       r, tk, rn, ld;
    logic [7:0] lh, lm, ls;
    for (int k = 0; k < 400; k++) begin
      r  = ($urandom_range(0, 99) == 0);
      tk = ($urandom_range(0, 3) != 0);
      rn = ($urandom_range(0, 4) != 0);
      ld = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 2))
        0: begin lh = 8'($urandom); lm = 8'($urandom); ls = 8'($urandom); end
        1: begin
          lh = bcd($urandom_range(0, 23));
          lm = bcd($urandom_range(0, 59));
          ls = bcd($urandom_range(0, 59));
        end
        default: begin
          lh = ($urandom_range(0, 1) != 0) ? 8'h23 : 8'h11;
          lm = 8'h59;
          ls = bcd($urandom_range(50, 59));
        end
      endcase
      cycle(r, tk, rn, ld, lh, lm, ls);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== expect_of(i)) begin
          bad++;
          $display("[TB] FAIL random mod%0d k=%0d got=%h want=%h",
                   mods[i], k, obs[i], expect_of(i));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      t[i] = 0; mp[i] = 1'b0; hp[i] = 1'b0; dp[i] = 1'b0; le[i] = 1'b0;
    end
    sys_rst = 1'b1; tick = 1'b0; run = 1'b0; load = 1'b0;
    ld_hh = 8'h00; ld_mm = 8'h00; ld_ss = 8'h00;
    test_reset();
    test_minute_rollover();
    test_day_wrap();
    test_hour12();
    test_invalid_load();
    test_pause();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
